// File: rtl/umips_reg_file_if.sv
// Bundle of write-back, decode read and debug signals around the GPR file.
// The master side is the pipeline (WB/ID/debug); the slave side is the register file.
interface umips_reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  // WB stage write-back
  logic              reg_write_w;
  logic              mem_to_reg_w;
  logic [DATA_W-1:0] read_data_w;
  logic [DATA_W-1:0] alu_out_w;
  logic [ADDR_W-1:0] write_reg_w;
  // ID stage read ports
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  // Debug / visibility
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] result_w;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output reg_write_w,
    output mem_to_reg_w,
    output read_data_w,
    output alu_out_w,
    output write_reg_w,
    output ra1,
    output ra2,
    output dbg_addr,
    input  rd1,
    input  rd2,
    input  dbg_data,
    input  result_w,
    input  wb_count
  );

  modport slave (
    input  reg_write_w,
    input  mem_to_reg_w,
    input  read_data_w,
    input  alu_out_w,
    input  write_reg_w,
    input  ra1,
    input  ra2,
    input  dbg_addr,
    output rd1,
    output rd2,
    output dbg_data,
    output result_w,
    output wb_count
  );
endinterface

// File: rtl/umips_reg_file.sv
// Architectural register file: selects the WB result, commits it to the GPRs,
// serves two bypassed decode read ports plus an unbypassed debug port, and
// counts committed writes.
module umips_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic              clk,
  input logic              rst,
  umips_reg_file_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [CNT_W-1:0]  wb_count_q;
  logic [DATA_W-1:0] result;
  logic              write_en;
  logic              bypass_en;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] dbg_data;

  // Write-back result select and commit qualification.
  // write_en is gated by reg_write_w first so X on the index cannot leak through.
  always_comb begin
    result    = bus.mem_to_reg_w ? bus.read_data_w : bus.alu_out_w;
    write_en  = bus.reg_write_w && (bus.write_reg_w != '0);
    // Bypass is suppressed while reset is held so ID sees the cleared state.
    bypass_en = write_en && rst;
  end

  // GPR storage; entry 0 is cleared on reset and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (write_en) begin
      gpr_q[bus.write_reg_w] <= result;
    end
  end

  // Committed-write counter, wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_count_q <= '0;
    end else if (write_en) begin
      wb_count_q <= wb_count_q + CNT_W'(1);
    end
  end

  // Decode read ports with same-cycle WB bypass; $zero always reads 0.
  always_comb begin
    rd1 = '0;
    if (bus.ra1 != '0) begin
      if (bypass_en && (bus.write_reg_w == bus.ra1)) begin
        rd1 = result;
      end else begin
        rd1 = gpr_q[bus.ra1];
      end
    end
    rd2 = '0;
    if (bus.ra2 != '0) begin
      if (bypass_en && (bus.write_reg_w == bus.ra2)) begin
        rd2 = result;
      end else begin
        rd2 = gpr_q[bus.ra2];
      end
    end
  end

  // Debug port returns the architectural value only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (bus.dbg_addr != '0) begin
      dbg_data = gpr_q[bus.dbg_addr];
    end
  end

  assign bus.result_w = result;
  assign bus.rd1      = rd1;
  assign bus.rd2      = rd2;
  assign bus.dbg_data = dbg_data;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_umips_reg_file.sv
// Directed self-checking bench for umips_reg_file (counter narrowed to 4 bits
// so the wrap is reachable quickly).
module tb_umips_reg_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  umips_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  umips_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [4:0] wr, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] dbg);
    bus.reg_write_w  = rw;
    bus.mem_to_reg_w = m2r;
    bus.read_data_w  = rdat;
    bus.alu_out_w    = alu;
    bus.write_reg_w  = wr;
    bus.ra1          = a1;
    bus.ra2          = a2;
    bus.dbg_addr     = dbg;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("reset_count_held", 32'(bus.wb_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: everything reads zero after reset
    for (int i = 0; i < 32; i++) begin
      bus.ra1      = 5'(i);
      bus.ra2      = 5'(i);
      bus.dbg_addr = 5'(i);
      #1;
      chk("reset_rd1", bus.rd1, 32'd0);
      chk("reset_rd2", bus.rd2, 32'd0);
      chk("reset_dbg", bus.dbg_data, 32'd0);
    end
    chk("reset_count", 32'(bus.wb_count), 32'd0);

    // 2: ALU write to $5 with same-cycle bypass
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0, 5'd5);
    #1;
    chk("wr5_bypass_rd1", bus.rd1, 32'hDEAD_BEEF);
    chk("wr5_result", bus.result_w, 32'hDEAD_BEEF);
    chk("wr5_dbg_before", bus.dbg_data, 32'd0);
    @(posedge clk); #1;
    chk("wr5_dbg_after", bus.dbg_data, 32'hDEAD_BEEF);
    chk("wr5_count", 32'(bus.wb_count), 32'd1);

    // 3: load-data select into $9
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd9, 5'd9, 5'd5, 5'd9);
    #1;
    chk("mux_result", bus.result_w, 32'h1234_5678);
    chk("mux_bypass_rd1", bus.rd1, 32'h1234_5678);
    chk("mux_rd2_old5", bus.rd2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("mux_dbg9", bus.dbg_data, 32'h1234_5678);
    chk("mux_count", 32'(bus.wb_count), 32'd2);

    // 4: writes to $zero are dropped and never bypassed
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("zero_rd1_same", bus.rd1, 32'd0);
    chk("zero_rd2_same", bus.rd2, 32'd0);
    @(posedge clk); #1;
    chk("zero_rd1_next", bus.rd1, 32'd0);
    chk("zero_rd2_next", bus.rd2, 32'd0);
    chk("zero_dbg_next", bus.dbg_data, 32'd0);
    chk("zero_count", 32'(bus.wb_count), 32'd2);

    // Seed $7 so the disabled-write case has a known old value
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0077, 5'd7, 5'd0, 5'd0, 5'd7);
    @(posedge clk); #1;
    chk("seed7_dbg", bus.dbg_data, 32'h0000_0077);
    chk("seed7_count", 32'(bus.wb_count), 32'd3);

    // 5: disabled write does not bypass or commit
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'hAAAA_AAAA, 5'd7, 5'd0, 5'd7, 5'd7);
    #1;
    chk("dis_rd2_same", bus.rd2, 32'h0000_0077);
    @(posedge clk); #1;
    chk("dis_rd2_next", bus.rd2, 32'h0000_0077);
    chk("dis_dbg7", bus.dbg_data, 32'h0000_0077);
    chk("dis_count", 32'(bus.wb_count), 32'd3);

    // X on index/data with write disabled must leave state alone
    @(negedge clk);
    drive(1'b0, 1'b0, 'x, 'x, 'x, 5'd5, 5'd7, 5'd9);
    @(posedge clk); #1;
    chk("x_rd1_5", bus.rd1, 32'hDEAD_BEEF);
    chk("x_rd2_7", bus.rd2, 32'h0000_0077);
    chk("x_dbg9", bus.dbg_data, 32'h1234_5678);
    chk("x_count", 32'(bus.wb_count), 32'd3);

    // 6: counter wrap -- 12 more writes to reach 15, then one more to wrap
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 32'(k + 100), 5'd10, 5'd0, 5'd0, 5'd10);
    end
    @(posedge clk); #1;
    chk("wrap_count15", 32'(bus.wb_count), 32'd15);
    chk("wrap_dbg10", bus.dbg_data, 32'd111);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1111, 5'd11, 5'd0, 5'd0, 5'd11);
    @(posedge clk); #1;
    chk("wrap_count0", 32'(bus.wb_count), 32'd0);
    chk("wrap_dbg11", bus.dbg_data, 32'h0000_1111);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_2222, 5'd11, 5'd0, 5'd0, 5'd11);
    @(posedge clk); #1;
    chk("wrap_count1", 32'(bus.wb_count), 32'd1);

    // Mid-operation reset: pending write discarded, state cleared immediately
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h0000_CAFE, 5'd12, 5'd12, 5'd5, 5'd12);
    #1;
    chk("pre_rst_bypass", bus.rd1, 32'h0000_CAFE);
    rst = 1'b0;
    #1;
    chk("rst_count_now", 32'(bus.wb_count), 32'd0);
    chk("rst_no_bypass", bus.rd1, 32'd0);
    chk("rst_rd2_cleared", bus.rd2, 32'd0);
    @(posedge clk); #1;
    chk("rst_dbg12", bus.dbg_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd12);
    @(posedge clk); #1;
    chk("post_rst_dbg12", bus.dbg_data, 32'd0);
    chk("post_rst_count", 32'(bus.wb_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
